// File: rtl/selftrigger_pkg.sv
// ----------------------------------------------------------------------------
// selftrigger_pkg
// Shared types and constants for the self-trigger readout scheduler slice.
//   sched_state_t      : scheduler FSM states (IDLE, OFFER)
//   DROP_W / TS_W      : drop counter and timestamp widths
//   NCH_DEFAULT        : default number of discriminator channels
//   HOLDOFF_W_DEFAULT  : default holdoff counter width
//   sat_add_drop()     : saturating add for the drop counter
// Optional feature macro used by this slice: SELFTRIG_TS_EN
// ----------------------------------------------------------------------------
package selftrigger_pkg;

    localparam int NCH_DEFAULT       = 8;
    localparam int HOLDOFF_W_DEFAULT = 12;
    localparam int DROP_W            = 16;
    localparam int TS_W              = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_t;

    // Adds an increment to the drop counter, clamping at all-ones so that a
    // long burst of rejected edges never wraps back to a small number.
    function automatic logic [DROP_W-1:0] sat_add_drop(
        input logic [DROP_W-1:0] count,
        input logic [DROP_W-1:0] inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, count} + {1'b0, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/selftrigger_channel_slot.sv
// ----------------------------------------------------------------------------
// selftrigger_channel_slot
// Per-channel front end: edge detection on the discriminator trigger,
// programmable holdoff (dead time), one-deep pending event flag and, with
// SELFTRIG_TS_EN defined, a timestamp captured on each accepted edge.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : gates acceptance of new edges
//   trig           : discriminator trigger level
//   holdoff        : dead time in cycles loaded on an accepted edge
//   clear          : handshake completed for this channel this cycle
//   ts / ts_q      : free-running timestamp in / captured timestamp out
//                    (SELFTRIG_TS_EN only)
//   pending        : an event is queued for this channel
//   reject         : single-cycle pulse for an edge that could not be queued
// ----------------------------------------------------------------------------
module selftrigger_channel_slot
    import selftrigger_pkg::*;
#(
    parameter int HOLDOFF_W = HOLDOFF_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 trig,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 clear,
`ifdef SELFTRIG_TS_EN
    input  logic [TS_W-1:0]      ts,
    output logic [TS_W-1:0]      ts_q,
`endif
    output logic                 pending,
    output logic                 reject
);

    logic                 trig_q;
    logic                 trig_qq;
    logic [HOLDOFF_W-1:0] holdoff_cnt;
    logic                 edge_det;
    logic                 accept;

    // The edge is detected between the two registered copies, so a trigger
    // first sampled at edge N is acted on at edge N+1.
    // A handshake clearing this channel in the same cycle frees the slot, so
    // a new edge with an expired holdoff keeps the flag set instead of
    // being dropped.
    assign edge_det = trig_q & ~trig_qq & enable;
    assign accept   = edge_det & (holdoff_cnt == '0) & (~pending | clear);
    assign reject   = edge_det & ~accept;

    // Trigger sampling, holdoff countdown and pending flag. The countdown
    // runs whether or not the block is enabled so a disabled period still
    // uses up dead time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q      <= 1'b0;
            trig_qq     <= 1'b0;
            holdoff_cnt <= '0;
            pending     <= 1'b0;
        end else begin
            trig_q  <= trig;
            trig_qq <= trig_q;
            if (accept) begin
                holdoff_cnt <= holdoff;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - 1'b1;
            end
            if (accept) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef SELFTRIG_TS_EN
    // Timestamp of the queued event, taken on the same edge that sets the
    // pending flag so it belongs to the event being offered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else if (accept) begin
            ts_q <= ts;
        end
    end
`endif

endmodule

// File: rtl/selftrigger_readout_scheduler.sv
// ----------------------------------------------------------------------------
// selftrigger_readout_scheduler
// Shares one frame-builder/readout path between NCH self-trigger channels.
// Each channel queues at most one event; queued channels are offered
// round-robin over a valid/ready handshake and rejected edges are counted.
// Optional feature macro: SELFTRIG_TS_EN (adds ts input and grant_ts output
// carrying the timestamp captured for the offered event).
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : when low, no new trigger edges are accepted
//   trig_in       : per-channel discriminator trigger levels
//   holdoff       : per-channel dead time after an accepted edge (cycles)
//   grant_valid   : a channel is being offered downstream
//   grant_ready   : downstream accepts the offer
//   grant_ch      : offered channel index
//   pending       : per-channel queued-event flags
//   drop_count    : saturating count of rejected edges, all channels
//   ts, grant_ts  : timestamp in / timestamp of offered event (macro only)
// ----------------------------------------------------------------------------
module selftrigger_readout_scheduler
    import selftrigger_pkg::*;
#(
    parameter int NCH       = NCH_DEFAULT,
    parameter int HOLDOFF_W = HOLDOFF_W_DEFAULT,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NCH-1:0]       trig_in,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 grant_valid,
    input  logic                 grant_ready,
    output logic [CH_W-1:0]      grant_ch,
    output logic [NCH-1:0]       pending,
    output logic [DROP_W-1:0]    drop_count
`ifdef SELFTRIG_TS_EN
    ,
    input  logic [TS_W-1:0]      ts,
    output logic [TS_W-1:0]      grant_ts
`endif
);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [CH_W-1:0]   grant_ch_q;
    logic [CH_W-1:0]   grant_ch_d;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   rr_ptr_d;
    logic [NCH-1:0]    clear_vec;
    logic [NCH-1:0]    reject_vec;
    logic [CH_W-1:0]   pick_ch;
    logic              pick_found;
    logic [DROP_W-1:0] reject_cnt;
    logic [DROP_W-1:0] drop_count_q;

`ifdef SELFTRIG_TS_EN
    logic [TS_W-1:0]   ts_bank [NCH];
`endif

    // One front-end slot per discriminator channel.
    for (genvar g = 0; g < NCH; g++) begin : g_slot
        selftrigger_channel_slot #(
            .HOLDOFF_W (HOLDOFF_W)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (enable),
            .trig    (trig_in[g]),
            .holdoff (holdoff),
            .clear   (clear_vec[g]),
`ifdef SELFTRIG_TS_EN
            .ts      (ts),
            .ts_q    (ts_bank[g]),
`endif
            .pending (pending[g]),
            .reject  (reject_vec[g])
        );
    end

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping
    // past the last channel back to channel 0.
    always_comb begin
        int               idx;
        logic [CH_W-1:0]  idx_c;
        pick_found = 1'b0;
        pick_ch    = '0;
        idx        = 0;
        idx_c      = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            idx_c = CH_W'(idx);
            if (!pick_found && pending[idx_c]) begin
                pick_found = 1'b1;
                pick_ch    = idx_c;
            end
        end
    end

    // Scheduler next state. The offered channel is latched on entry to
    // OFFER and held until the handshake, so grant_ch cannot move under an
    // open offer; the mandatory IDLE cycle after each handshake lets the
    // cleared pending bit settle before the next pick.
    always_comb begin
        state_d    = state_q;
        grant_ch_d = grant_ch_q;
        rr_ptr_d   = rr_ptr_q;
        clear_vec  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_ch_d = pick_ch;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (grant_ready) begin
                    clear_vec[grant_ch_q] = 1'b1;
                    rr_ptr_d = (grant_ch_q == CH_W'(NCH - 1)) ? '0
                                                               : grant_ch_q + CH_W'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_ch_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_ch_q <= grant_ch_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Number of channels that rejected an edge this cycle; several channels
    // can drop in the same cycle and each one counts.
    always_comb begin
        reject_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            reject_cnt = reject_cnt + DROP_W'(reject_vec[i]);
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= sat_add_drop(drop_count_q, reject_cnt);
        end
    end

    // grant_valid comes straight from the state register, so grant_ready
    // has no combinational path to it.
    assign grant_valid = (state_q == OFFER);
    assign grant_ch    = grant_ch_q;
    assign drop_count  = drop_count_q;

`ifdef SELFTRIG_TS_EN
    assign grant_ts = ts_bank[grant_ch_q];
`endif

endmodule

// File: tb/tb_selftrigger_readout_scheduler.sv
// ----------------------------------------------------------------------------
// tb_selftrigger_readout_scheduler
// Directed bench for selftrigger_readout_scheduler with NCH=8, HOLDOFF_W=12.
// Every expected value below is worked out by hand from the cycle timing:
// a trigger sampled at edge S is accepted at S+1, offered from S+2, and the
// handshake at the next edge with grant_ready high clears it.
// ----------------------------------------------------------------------------
module tb_selftrigger_readout_scheduler;

    localparam int NCH       = 8;
    localparam int HOLDOFF_W = 12;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic [NCH-1:0]       trig_in;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 grant_valid;
    logic                 grant_ready;
    logic [2:0]           grant_ch;
    logic [NCH-1:0]       pending;
    logic [15:0]          drop_count;
`ifdef SELFTRIG_TS_EN
    logic [63:0]          ts = '0;
    logic [63:0]          grant_ts;
`endif

    int vectors     = 0;
    int miscompares = 0;

    selftrigger_readout_scheduler #(
        .NCH       (NCH),
        .HOLDOFF_W (HOLDOFF_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .trig_in     (trig_in),
        .holdoff     (holdoff),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_ch    (grant_ch),
        .pending     (pending),
        .drop_count  (drop_count)
`ifdef SELFTRIG_TS_EN
        ,
        .ts          (ts),
        .grant_ts    (grant_ts)
`endif
    );

    // 100 MHz-style clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

`ifdef SELFTRIG_TS_EN
    // Free-running timestamp, only present with the timestamp feature.
    always @(posedge clk) ts <= ts + 64'd1;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] trig, input logic ready);
        trig_in     = trig;
        grant_ready = ready;
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick(2);
        checkOutput("rst_gv",   32'(grant_valid), 32'd0);
        checkOutput("rst_pend", 32'(pending),     32'h00);
        checkOutput("rst_drop", 32'(drop_count),  32'd0);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int         exp_drop [4];
        logic       exp_pend [4];
        logic [2:0] grants3  [3];
        logic [2:0] grants2  [2];

        exp_drop = '{0, 1, 2, 2};
        exp_pend = '{1'b1, 1'b0, 1'b0, 1'b1};
        grants3  = '{3'd0, 3'd5, 3'd7};
        grants2  = '{3'd0, 3'd5};

        reset_n     = 1'b0;
        enable      = 1'b1;
        trig_in     = '0;
        grant_ready = 1'b1;
        holdoff     = 12'd10;

        // Reset values while reset is held.
        #2;
        checkOutput("reset_gv",   32'(grant_valid), 32'd0);
        checkOutput("reset_ch",   32'(grant_ch),    32'd0);
        checkOutput("reset_pend", 32'(pending),     32'h00);
        checkOutput("reset_drop", 32'(drop_count),  32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Single ch3 pulse: pending one edge after sampling, offer one edge
        // later, one cycle wide with grant_ready high.
        applyStimulus(8'h08, 1'b1);
        tick;
        checkOutput("t1_pend_early", 32'(pending), 32'h00);
        applyStimulus(8'h00, 1'b1);
        tick;
        checkOutput("t1_pend",     32'(pending),     32'h08);
        checkOutput("t1_gv_early", 32'(grant_valid), 32'd0);
        tick;
        checkOutput("t1_gv",   32'(grant_valid), 32'd1);
        checkOutput("t1_ch",   32'(grant_ch),    32'd3);
        tick;
        checkOutput("t1_gv_low",   32'(grant_valid), 32'd0);
        checkOutput("t1_pend_clr", 32'(pending),     32'h00);
        checkOutput("t1_drop",     32'(drop_count),  32'd0);
        tick(12);

        // ch3 pulses every 4 cycles with holdoff 10: the 2nd and 3rd fall in
        // the dead time, the 4th (offset 12) is accepted again.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(8'h08, 1'b1);
            tick;
            applyStimulus(8'h00, 1'b1);
            tick;
            checkOutput($sformatf("t2_pend_%0d", k), 32'(pending[3]), 32'(exp_pend[k]));
            checkOutput($sformatf("t2_drop_%0d", k), 32'(drop_count), 32'(exp_drop[k]));
            tick(2);
        end
        tick(12);

        // Fresh start so rr_ptr is 0: ch0/5/7 together are served 0,5,7.
        doReset();
        applyStimulus(8'hA1, 1'b1);
        tick;
        applyStimulus(8'h00, 1'b1);
        tick;
        checkOutput("t3_pend", 32'(pending), 32'hA1);
        for (int g = 0; g < 3; g++) begin
            tick;
            checkOutput($sformatf("t3_gv_%0d", g), 32'(grant_valid), 32'd1);
            checkOutput($sformatf("t3_ch_%0d", g), 32'(grant_ch),    32'(grants3[g]));
            tick;
            checkOutput($sformatf("t3_gap_%0d", g), 32'(grant_valid), 32'd0);
        end
        checkOutput("t3_pend_done", 32'(pending), 32'h00);
        tick(12);

        // After ch7, rr_ptr wraps to 0: ch0+ch5 served 0 then 5.
        applyStimulus(8'h21, 1'b1);
        tick;
        applyStimulus(8'h00, 1'b1);
        tick;
        for (int g = 0; g < 2; g++) begin
            tick;
            checkOutput($sformatf("t3b_ch_%0d", g), 32'(grant_ch),    32'(grants2[g]));
            checkOutput($sformatf("t3b_gv_%0d", g), 32'(grant_valid), 32'd1);
            tick;
        end
        tick(12);

        // Back-pressure: ch2 offered with grant_ready low for 20 cycles; a
        // second ch2 edge after its holdoff expired still drops (pending).
        holdoff = 12'd4;
        applyStimulus(8'h04, 1'b0);
        tick;
        applyStimulus(8'h00, 1'b0);
        tick;
        tick;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) trig_in = 8'h04;
            if (i == 6) trig_in = 8'h00;
            tick;
            checkOutput($sformatf("t4_gv_%0d", i), 32'(grant_valid), 32'd1);
            checkOutput($sformatf("t4_ch_%0d", i), 32'(grant_ch),    32'd2);
        end
        checkOutput("t4_drop", 32'(drop_count), 32'd1);
        checkOutput("t4_pend", 32'(pending),    32'h04);
        grant_ready = 1'b1;
        tick;
        checkOutput("t4_gv_low",   32'(grant_valid), 32'd0);
        checkOutput("t4_pend_clr", 32'(pending),     32'h00);

        // Saturation: all eight channels held pending, then 8750 further
        // all-channel pulses reject 8 edges each (70000 total).
        holdoff     = 12'd0;
        grant_ready = 1'b0;
        tick(2);
        applyStimulus(8'hFF, 1'b0);
        tick;
        applyStimulus(8'h00, 1'b0);
        tick;
        checkOutput("t5_pend_all", 32'(pending),    32'hFF);
        checkOutput("t5_drop0",    32'(drop_count), 32'd1);
        for (int p = 1; p <= 8750; p++) begin
            applyStimulus(8'hFF, 1'b0);
            tick;
            applyStimulus(8'h00, 1'b0);
            tick;
            if (p == 1)    checkOutput("t5_drop_multi", 32'(drop_count), 32'd9);
            if (p == 8000) checkOutput("t5_drop_8000",  32'(drop_count), 32'd64001);
        end
        checkOutput("t5_drop_sat", 32'(drop_count), 32'hFFFF);
        checkOutput("t5_ch_hold",  32'(grant_ch),   32'd3);

        // Drain ch3..ch7, leaving ch0..ch2 pending with ch0 on offer.
        grant_ready = 1'b1;
        tick(9);
        grant_ready = 1'b0;
        tick;
        checkOutput("t6_gv",   32'(grant_valid), 32'd1);
        checkOutput("t6_ch",   32'(grant_ch),    32'd0);
        checkOutput("t6_pend", 32'(pending),     32'h07);

        // Asynchronous reset mid-offer clears everything without a clock.
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_gv",   32'(grant_valid), 32'd0);
        checkOutput("t6_rst_pend", 32'(pending),     32'h00);
        checkOutput("t6_rst_drop", 32'(drop_count),  32'd0);
        tick(2);
        reset_n     = 1'b1;
        grant_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            checkOutput($sformatf("t6_quiet_%0d", i), 32'(grant_valid), 32'd0);
        end
        checkOutput("t6_quiet_pend", 32'(pending), 32'h00);

        // enable low ignores a ch6 edge; once enabled, a new ch6 edge is
        // queued and offered.
        enable = 1'b0;
        applyStimulus(8'h40, 1'b1);
        tick;
        applyStimulus(8'h00, 1'b1);
        tick(2);
        checkOutput("t7_dis_pend", 32'(pending),     32'h00);
        checkOutput("t7_dis_gv",   32'(grant_valid), 32'd0);
        checkOutput("t7_dis_drop", 32'(drop_count),  32'd0);
        enable = 1'b1;
        applyStimulus(8'h40, 1'b1);
        tick;
        applyStimulus(8'h00, 1'b1);
        tick;
        checkOutput("t7_pend", 32'(pending), 32'h40);
        tick;
        checkOutput("t7_gv", 32'(grant_valid), 32'd1);
        checkOutput("t7_ch", 32'(grant_ch),    32'd6);
        tick;
        checkOutput("t7_done", 32'(pending), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
